card_number_entry: RTL and testbench

Upstream front-end for the BIN lookup. It collects card digits from a decoded keypad stream into a 16-digit buffer, with backspace and clear. On enter it validates the number with a sequential Luhn check, then presents the first six digits to the BIN lookup with a one-cycle start pulse. It waits for the lookup to finish, with a timeout, and latches a result status for the display layer.

---
 rtl/card_entry_pkg.sv | 25 ++
 rtl/luhn_checker.sv | 57 +++++
 rtl/card_number_entry.sv | 206 ++++++++++++++++++++
 tb/tb_card_number_entry.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/card_entry_pkg.sv
// Shared constants, state encoding and helpers for the card number entry front-end.
package card_entry_pkg;

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam int unsigned DEF_MIN_DIGITS = 13;
  localparam int unsigned DEF_MAX_DIGITS = 16;
  localparam int unsigned BUF_W          = 64;
  localparam int unsigned COUNT_W        = 5;

  typedef enum logic [2:0] {
    ST_ENTRY  = 3'd0,
    ST_CHECK  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/luhn_checker.sv
// Sequential Luhn check: walks the buffer right-to-left, one digit per cycle.
module luhn_checker (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [4:0] i_count,
  input  logic [3:0] i_digit,
  output logic [3:0] o_sel,
  output logic       o_done_c,
  output logic       o_ok_c
);

  logic       r_active;
  logic [3:0] r_idx;
  logic       r_pos;
  logic [7:0] r_sum;

  logic [4:0] w_dbl;
  logic [3:0] w_v;
  logic [7:0] w_sum;

  // Weight of the current digit; odd positions from the right are doubled.
  always_comb begin
    w_dbl = {i_digit, 1'b0};
    w_v   = i_digit;
    if (r_pos) begin
      w_v = (w_dbl > 5'd9) ? 4'(w_dbl - 5'd9) : w_dbl[3:0];
    end
    w_sum = r_sum + 8'(w_v);
  end

  assign o_sel    = r_idx;
  assign o_done_c = r_active && (r_idx == 4'd0);
  assign o_ok_c   = ((w_sum % 8'd10) == 8'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_idx    <= 4'd0;
      r_pos    <= 1'b0;
      r_sum    <= 8'd0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_idx    <= 4'(i_count - 5'd1);
      r_pos    <= 1'b0;
      r_sum    <= 8'd0;
    end else if (i_abort || o_done_c) begin
      r_active <= 1'b0;
    end else if (r_active) begin
      r_idx <= r_idx - 4'd1;
      r_pos <= ~r_pos;
      r_sum <= w_sum;
    end
  end

endmodule

// File: rtl/card_number_entry.sv
// Keypad digit collection, Luhn validation and BIN lookup handshake with timeout.
module card_number_entry
  import card_entry_pkg::*;
#(
  parameter int unsigned MIN_DIGITS     = DEF_MIN_DIGITS,
  parameter int unsigned MAX_DIGITS     = DEF_MAX_DIGITS,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        lookup_done,
  input  logic        lookup_found,
  output logic [3:0]  d5,
  output logic [3:0]  d4,
  output logic [3:0]  d3,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0,
  output logic        start,
  output logic [4:0]  digit_count,
  output logic [63:0] digits,
  output logic        entry_error,
  output logic        busy,
  output logic        result_valid,
  output logic        luhn_ok,
  output logic        bin_found,
  output logic        timeout
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t              r_state, w_state_nxt;
  logic [BUF_W-1:0]    r_digits, w_digits_nxt;
  logic [COUNT_W-1:0]  r_count, w_count_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic                r_err, w_err_nxt;
  logic                r_start, w_start_nxt;
  logic                r_luhn, w_luhn_nxt;
  logic                r_found, w_found_nxt;
  logic                r_tmo, w_tmo_nxt;
  logic                r_busy, r_result;
  logic                r_done_prev;

  logic                w_clear_key, w_abort, w_done_edge;
  logic                w_chk_start, w_chk_done, w_chk_ok;
  logic [3:0]          w_sel, w_sel_digit;
  logic [5:0]          w_sh_add, w_sh_del;

  // Nibble offsets: slot k lives at bit 60-4k, i.e. {~k, 2'b00} for k < 16.
  assign w_sh_add    = {~r_count[3:0], 2'b00};
  assign w_sh_del    = {~(r_count[3:0] - 4'd1), 2'b00};
  assign w_sel_digit = 4'(r_digits >> {~w_sel, 2'b00});

  luhn_checker u_luhn (
    .i_clk    (CLOCK_50),
    .i_rst_n  (resetn),
    .i_start  (w_chk_start),
    .i_abort  (w_abort),
    .i_count  (r_count),
    .i_digit  (w_sel_digit),
    .o_sel    (w_sel),
    .o_done_c (w_chk_done),
    .o_ok_c   (w_chk_ok)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= ST_ENTRY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_count_nxt  = r_count;
    w_wait_nxt   = r_wait_cnt;
    w_err_nxt    = 1'b0;
    w_start_nxt  = 1'b0;
    w_luhn_nxt   = r_luhn;
    w_found_nxt  = r_found;
    w_tmo_nxt    = r_tmo;
    w_chk_start  = 1'b0;
    w_clear_key  = key_valid && (key_code == KEY_CLEAR);
    w_abort      = w_clear_key && (r_state != ST_ENTRY);
    w_done_edge  = lookup_done && !r_done_prev;

    case (r_state)
      ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (r_count < COUNT_W'(MAX_DIGITS)) begin
              w_digits_nxt = r_digits | (BUF_W'(key_code) << w_sh_add);
              w_count_nxt  = r_count + 5'd1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if (key_code == KEY_BKSP) begin
            if (r_count != 5'd0) begin
              w_digits_nxt = r_digits & ~(BUF_W'(4'hF) << w_sh_del);
              w_count_nxt  = r_count - 5'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            w_digits_nxt = '0;
            w_count_nxt  = '0;
          end else if (key_code == KEY_ENTER) begin
            if (r_count < COUNT_W'(MIN_DIGITS)) begin
              w_err_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_CHECK;
              w_chk_start = 1'b1;
              w_luhn_nxt  = 1'b0;
              w_found_nxt = 1'b0;
              w_tmo_nxt   = 1'b0;
            end
          end
        end
      end
      ST_CHECK: begin
        if (w_chk_done) begin
          w_luhn_nxt  = w_chk_ok;
          w_found_nxt = 1'b0;
          w_tmo_nxt   = 1'b0;
          w_start_nxt = w_chk_ok;
          w_state_nxt = w_chk_ok ? ST_LAUNCH : ST_RESULT;
        end
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_WAIT;
        w_wait_nxt  = '0;
      end
      ST_WAIT: begin
        // A fresh done edge takes priority over the terminal count.
        if (w_done_edge) begin
          w_found_nxt = lookup_found;
          w_tmo_nxt   = 1'b0;
          w_state_nxt = ST_RESULT;
        end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          w_found_nxt = 1'b0;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ST_RESULT;
        end else begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_RESULT: ;
      default: w_state_nxt = ST_ENTRY;
    endcase

    if (w_abort) begin
      w_state_nxt  = ST_ENTRY;
      w_digits_nxt = '0;
      w_count_nxt  = '0;
      w_start_nxt  = 1'b0;
      w_luhn_nxt   = 1'b0;
      w_found_nxt  = 1'b0;
      w_tmo_nxt    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_digits    <= '0;
      r_count     <= '0;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_luhn      <= 1'b0;
      r_found     <= 1'b0;
      r_tmo       <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= 1'b0;
      r_done_prev <= 1'b0;
    end else begin
      r_digits    <= w_digits_nxt;
      r_count     <= w_count_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_err       <= w_err_nxt;
      r_start     <= w_start_nxt;
      r_luhn      <= w_luhn_nxt;
      r_found     <= w_found_nxt;
      r_tmo       <= w_tmo_nxt;
      r_busy      <= (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_LAUNCH) ||
                     (w_state_nxt == ST_WAIT);
      r_result    <= (w_state_nxt == ST_RESULT);
      r_done_prev <= lookup_done;
    end
  end

  assign digits       = r_digits;
  assign digit_count  = r_count;
  assign d5           = r_digits[63:60];
  assign d4           = r_digits[59:56];
  assign d3           = r_digits[55:52];
  assign d2           = r_digits[51:48];
  assign d1           = r_digits[47:44];
  assign d0           = r_digits[43:40];
  assign start        = r_start;
  assign entry_error  = r_err;
  assign busy         = r_busy;
  assign result_valid = r_result;
  assign luhn_ok      = r_luhn;
  assign bin_found    = r_found;
  assign timeout      = r_tmo;

endmodule

// File: tb/tb_card_number_entry.sv
// Directed bench for card_number_entry: entry, Luhn, launch, lookup wait and abort paths.
module tb_card_number_entry;

  localparam int unsigned TB_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        lookup_done;
  logic        lookup_found;
  logic [3:0]  d5, d4, d3, d2, d1, d0;
  logic        start;
  logic [4:0]  digit_count;
  logic [63:0] digits;
  logic        entry_error, busy, result_valid, luhn_ok, bin_found, timeout;

  int checks   = 0;
  int failures = 0;

  card_number_entry #(
    .MIN_DIGITS     (13),
    .MAX_DIGITS     (16),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .lookup_done  (lookup_done),
    .lookup_found (lookup_found),
    .d5           (d5),
    .d4           (d4),
    .d3           (d3),
    .d2           (d2),
    .d1           (d1),
    .d0           (d0),
    .start        (start),
    .digit_count  (digit_count),
    .digits       (digits),
    .entry_error  (entry_error),
    .busy         (busy),
    .result_valid (result_valid),
    .luhn_ok      (luhn_ok),
    .bin_found    (bin_found),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  task automatic load(input logic [63:0] num, input int n);
    for (int i = 0; i < n; i++) press(num[63-4*i -: 4]);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, 64'(digit_count), 64'd0);
    chk({tag, "_digits"}, digits, 64'd0);
    chk({tag, "_flags"},
        64'({start, entry_error, busy, result_valid, luhn_ok, bin_found, timeout}), 64'd0);
    chk({tag, "_dsix"}, 64'({d5, d4, d3, d2, d1, d0}), 64'd0);
  endtask

  // Advances until start is seen (bounded); returns 1 if it appeared.
  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (start) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit seen;
    int nstart;

    resetn       = 1'b0;
    key_valid    = 1'b0;
    key_code     = 4'hF;
    lookup_done  = 1'b0;
    lookup_found = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    resetn = 1'b1;
    tick();

    // Valid number, lookup hit.
    press(4'd4);
    chk("first_digit_count", 64'(digit_count), 64'd1);
    chk("first_digit_buf", digits, 64'h4000_0000_0000_0000);
    load(64'h1111_1111_1111_1110, 15);
    chk("full_count", 64'(digit_count), 64'd16);
    chk("full_buf", digits, 64'h4111_1111_1111_1111);
    press(4'hB);
    chk("check_busy_t1", 64'({busy, start, result_valid}), 64'b100);
    for (int i = 0; i < 15; i++) tick();
    chk("check_t16", 64'({busy, start, result_valid}), 64'b100);
    tick();
    chk("start_t17", 64'({busy, start, result_valid}), 64'b110);
    chk("dsix_t17", 64'({d5, d4, d3, d2, d1, d0}), 64'h41_1111);
    tick();
    chk("start_one_cycle", 64'({busy, start}), 64'b10);
    lookup_done  = 1'b1;
    lookup_found = 1'b1;
    tick();
    lookup_done  = 1'b0;
    lookup_found = 1'b0;
    chk("hit_result",
        64'({result_valid, busy, luhn_ok, bin_found, timeout}), 64'b10110);
    press(4'd7);
    chk("result_ignores_digit", 64'({entry_error, result_valid, digit_count}), 64'({2'b01, 5'd16}));
    press(4'hC);
    chk_idle("result_clear");

    // Luhn failure: no start, result at T+17.
    load(64'h4111_1111_1111_1112, 16);
    press(4'hB);
    nstart = 0;
    for (int i = 0; i < 15; i++) begin
      if (start) nstart++;
      tick();
    end
    chk("bad_t16_rv", 64'(result_valid), 64'd0);
    tick();
    if (start) nstart++;
    chk("bad_t17", 64'({result_valid, busy, luhn_ok, bin_found, timeout}), 64'b10000);
    chk("bad_no_start", 64'(nstart), 64'd0);
    press(4'hC);

    // Too few digits.
    load(64'h1234_5678_9012_0000, 12);
    press(4'hB);
    chk("short_enter", 64'({entry_error, busy, digit_count}), 64'({2'b10, 5'd12}));
    tick();
    chk("short_err_pulse", 64'(entry_error), 64'd0);
    press(4'hC);

    // Overflow and backspace.
    load(64'h1234_5678_9012_3456, 16);
    press(4'd9);
    chk("overflow", 64'({entry_error, digit_count}), 64'({1'b1, 5'd16}));
    chk("overflow_buf", digits, 64'h1234_5678_9012_3456);
    press(4'hA);
    press(4'hA);
    chk("bksp_count", 64'({entry_error, digit_count}), 64'd14);
    chk("bksp_buf", digits, 64'h1234_5678_9012_3400);
    press(4'hC);
    press(4'hA);
    chk("bksp_empty", 64'({entry_error, digit_count}), 64'd0);

    // Timeout with lookup_done held low.
    load(64'h4111_1111_1111_1111, 16);
    press(4'hB);
    wait_start(seen);
    chk("tmo_start_seen", 64'(seen), 64'd1);
    for (int i = 0; i < int'(TB_TIMEOUT); i++) tick();
    chk("tmo_before", 64'({result_valid, busy}), 64'b01);
    tick();
    chk("tmo_result", 64'({result_valid, luhn_ok, bin_found, timeout}), 64'b1101);
    press(4'hC);

    // Done edge on the terminal-count cycle wins.
    load(64'h4111_1111_1111_1111, 16);
    press(4'hB);
    wait_start(seen);
    chk("tie_start_seen", 64'(seen), 64'd1);
    for (int i = 0; i < int'(TB_TIMEOUT); i++) tick();
    lookup_done  = 1'b1;
    lookup_found = 1'b1;
    tick();
    lookup_done  = 1'b0;
    lookup_found = 1'b0;
    chk("tie_result", 64'({result_valid, luhn_ok, bin_found, timeout}), 64'b1110);
    press(4'hC);

    // Stale high lookup_done is not completion.
    lookup_done = 1'b1;
    load(64'h4111_1111_1111_1111, 16);
    press(4'hB);
    wait_start(seen);
    chk("stale_start_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("stale_wait", 64'({result_valid, busy}), 64'b01);
    lookup_done = 1'b0;
    tick();
    lookup_done  = 1'b1;
    lookup_found = 1'b0;
    tick();
    lookup_done = 1'b0;
    chk("stale_result", 64'({result_valid, luhn_ok, bin_found, timeout}), 64'b1100);
    press(4'hC);

    // Clear during WAIT.
    load(64'h4111_1111_1111_1111, 16);
    press(4'hB);
    wait_start(seen);
    chk("abort_start_seen", 64'(seen), 64'd1);
    tick();
    tick();
    tick();
    press(4'hC);
    chk_idle("wait_clear");

    // Reset during CHECK.
    load(64'h4111_1111_1111_1111, 16);
    press(4'hB);
    tick();
    tick();
    tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk_idle("check_reset");
    tick();
    resetn = 1'b1;
    tick();
    chk_idle("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
